// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read port,
// programmable threshold flags, occupancy count and per-cycle handshake/error pulses.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int PROG_FULL  = 12,
  parameter int PROG_EMPTY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_AFULL = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_PFULL = (ADDR_WIDTH+1)'(PROG_FULL);
  localparam logic [ADDR_WIDTH:0]   CNT_PEMPT = (ADDR_WIDTH+1)'(PROG_EMPTY);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_accept, rd_accept;

  // Flags are decoded from the registered count only, so they describe the pre-edge state.
  assign full         = (count_q == CNT_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AFULL);
  assign almost_empty = (count_q <= CNT_ONE);
  assign prog_full    = (count_q >= CNT_PFULL);
  assign prog_empty   = (count_q <= CNT_PEMPT);
  assign data_count   = count_q;

  assign wr_accept = wr_en & ~full & ~rst;
  assign rd_accept = rd_en & ~empty & ~rst;

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_accept;
      overflow_q  <= wr_en & full;
      underflow_q <= rd_en & empty;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout  = mem_q[rd_ptr_q];
      assign valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  valid_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_accept;
          if (rd_accept) dout_q <= mem_q[rd_ptr_q];
        end
      end

      assign dout  = dout_q;
      assign valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a standard-mode and an FWFT instance side by side,
// each checked against a queue-based reference model.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst;

  logic       wr_s, rd_s;
  logic [7:0] din_s, dout_s;
  logic       valid_s, ack_s, ovf_s, unf_s, full_s, empty_s, af_s, ae_s, pf_s, pe_s;
  logic [4:0] cnt_s;

  logic       wr_f, rd_f;
  logic [7:0] din_f, dout_f;
  logic       valid_f, ack_f, ovf_f, unf_f, full_f, empty_f, af_f, ae_f, pf_f, pe_f;
  logic [4:0] cnt_f;

  param_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .PROG_FULL(12), .PROG_EMPTY(3)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_s), .din(din_s), .rd_en(rd_s), .dout(dout_s),
    .valid(valid_s), .wr_ack(ack_s), .overflow(ovf_s), .underflow(unf_s),
    .full(full_s), .empty(empty_s), .almost_full(af_s), .almost_empty(ae_s),
    .prog_full(pf_s), .prog_empty(pe_s), .data_count(cnt_s));

  param_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .PROG_FULL(12), .PROG_EMPTY(3)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr_f), .din(din_f), .rd_en(rd_f), .dout(dout_f),
    .valid(valid_f), .wr_ack(ack_f), .overflow(ovf_f), .underflow(unf_f),
    .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .prog_full(pf_f), .prog_empty(pe_f), .data_count(cnt_f));

  int total = 0;
  int bad   = 0;

  // Reference model: contents as queues, plus the pulses/data expected after the last edge.
  logic [7:0] qs[$];
  logic [7:0] qf[$];
  logic       e_ack_s, e_ovf_s, e_unf_s, e_valid_s;
  logic [7:0] e_dout_s;
  logic       e_ack_f, e_ovf_f, e_unf_f;

  // {full, empty, almost_full, almost_empty, prog_full, prog_empty} for an occupancy n
  function automatic logic [5:0] flags(input int n);
    return {n == 16, n == 0, n >= 15, n <= 1, n >= 12, n <= 3};
  endfunction

  task automatic step(input logic ws, input logic rs, input logic [7:0] ds,
                      input logic wf, input logic rf, input logic [7:0] df);
    int  ns, nf;
    logic wa, ra;
    wr_s = ws; rd_s = rs; din_s = ds;
    wr_f = wf; rd_f = rf; din_f = df;
    ns = qs.size();
    nf = qf.size();
    @(posedge clk);
    wa = ws && (ns < 16);
    ra = rs && (ns > 0);
    e_ack_s = wa; e_ovf_s = ws && !wa; e_unf_s = rs && !ra; e_valid_s = ra;
    if (ra) e_dout_s = qs.pop_front();
    if (wa) qs.push_back(ds);
    wa = wf && (nf < 16);
    ra = rf && (nf > 0);
    e_ack_f = wa; e_ovf_f = wf && !wa; e_unf_f = rf && !ra;
    if (ra) void'(qf.pop_front());
    if (wa) qf.push_back(df);
    #1;
  endtask

  task automatic model_reset();
    qs.delete(); qf.delete();
    e_ack_s = 0; e_ovf_s = 0; e_unf_s = 0; e_valid_s = 0; e_dout_s = 8'h00;
    e_ack_f = 0; e_ovf_f = 0; e_unf_f = 0;
  endtask

  task automatic test_reset();
    wr_s = 0; rd_s = 0; din_s = 0; wr_f = 0; rd_f = 0; din_f = 0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    model_reset();
    total++;
    if ({full_s, empty_s, af_s, ae_s, pf_s, pe_s, valid_s, ack_s, ovf_s, unf_s} !== 10'b0101010000) begin
      bad++;
      $display("FAIL reset_std_outputs: got %b expected %b",
               {full_s, empty_s, af_s, ae_s, pf_s, pe_s, valid_s, ack_s, ovf_s, unf_s}, 10'b0101010000);
    end
    total++;
    if ({full_f, empty_f, af_f, ae_f, pf_f, pe_f, valid_f, ack_f, ovf_f, unf_f} !== 10'b0101010000) begin
      bad++;
      $display("FAIL reset_fw_outputs: got %b expected %b",
               {full_f, empty_f, af_f, ae_f, pf_f, pe_f, valid_f, ack_f, ovf_f, unf_f}, 10'b0101010000);
    end
    total++;
    if (cnt_s !== 5'd0 || cnt_f !== 5'd0 || dout_s !== 8'h00) begin
      bad++;
      $display("FAIL reset_count_dout: got cnt_s=%0d cnt_f=%0d dout_s=%0h expected 0 0 0", cnt_s, cnt_f, dout_s);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i), 1, 0, 8'(i + 8'h40));
      total++;
      if ({full_s, empty_s, af_s, ae_s, pf_s, pe_s} !== flags(qs.size()) || int'(cnt_s) !== qs.size() || ack_s !== 1'b1) begin
        bad++;
        $display("FAIL fill_std_w%0d: got flags=%b cnt=%0d ack=%b expected flags=%b cnt=%0d ack=1",
                 i + 1, {full_s, empty_s, af_s, ae_s, pf_s, pe_s}, cnt_s, ack_s, flags(qs.size()), qs.size());
      end
      total++;
      if ({full_f, empty_f, af_f, ae_f, pf_f, pe_f} !== flags(qf.size()) || dout_f !== qf[0] || valid_f !== 1'b1) begin
        bad++;
        $display("FAIL fill_fw_w%0d: got flags=%b dout=%0h valid=%b expected flags=%b dout=%0h valid=1",
                 i + 1, {full_f, empty_f, af_f, ae_f, pf_f, pe_f}, dout_f, valid_f, flags(qf.size()), qf[0]);
      end
    end
    step(1, 0, 8'hEE, 1, 0, 8'hEE);
    total++;
    if (ovf_s !== 1'b1 || ack_s !== 1'b0 || cnt_s !== 5'd16 || ovf_f !== 1'b1 || cnt_f !== 5'd16) begin
      bad++;
      $display("FAIL overflow_17th: got ovf=%b ack=%b cnt=%0d ovf_f=%b cnt_f=%0d expected 1 0 16 1 16",
               ovf_s, ack_s, cnt_s, ovf_f, cnt_f);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 8'h00, 0, 1, 8'h00);
      total++;
      if (dout_s !== 8'(i) || valid_s !== 1'b1 || int'(cnt_s) !== qs.size() ||
          {full_s, empty_s, af_s, ae_s, pf_s, pe_s} !== flags(qs.size())) begin
        bad++;
        $display("FAIL drain_std_r%0d: got dout=%0h valid=%b cnt=%0d flags=%b expected dout=%0h valid=1 cnt=%0d flags=%b",
                 i + 1, dout_s, valid_s, cnt_s, {full_s, empty_s, af_s, ae_s, pf_s, pe_s}, i, qs.size(), flags(qs.size()));
      end
      total++;
      if (valid_f !== (qf.size() > 0) || (qf.size() > 0 && dout_f !== qf[0])) begin
        bad++;
        $display("FAIL drain_fw_r%0d: got dout=%0h valid=%b expected valid=%b", i + 1, dout_f, valid_f, qf.size() > 0);
      end
    end
    step(0, 1, 8'h00, 0, 1, 8'h00);
    total++;
    if (unf_s !== 1'b1 || valid_s !== 1'b0 || empty_s !== 1'b1 || unf_f !== 1'b1 || valid_f !== 1'b0) begin
      bad++;
      $display("FAIL underflow_17th: got unf=%b valid=%b empty=%b unf_f=%b valid_f=%b expected 1 0 1 1 0",
               unf_s, valid_s, empty_s, unf_f, valid_f);
    end
    step(0, 0, 8'h00, 0, 0, 8'h00);
    total++;
    if (unf_s !== 1'b0 || unf_f !== 1'b0 || valid_s !== 1'b0) begin
      bad++;
      $display("FAIL underflow_pulse_width: got unf=%b unf_f=%b valid=%b expected 0 0 0", unf_s, unf_f, valid_s);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom), 1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 8'($urandom), 1, 1, 8'($urandom));
      total++;
      if (cnt_s !== 5'd8 || dout_s !== e_dout_s || valid_s !== 1'b1 || ack_s !== 1'b1) begin
        bad++;
        $display("FAIL wrap_std_c%0d: got cnt=%0d dout=%0h valid=%b ack=%b expected cnt=8 dout=%0h valid=1 ack=1",
                 i, cnt_s, dout_s, valid_s, ack_s, e_dout_s);
      end
      total++;
      if (cnt_f !== 5'd8 || dout_f !== qf[0] || valid_f !== 1'b1) begin
        bad++;
        $display("FAIL wrap_fw_c%0d: got cnt=%0d dout=%0h valid=%b expected cnt=8 dout=%0h valid=1",
                 i, cnt_f, dout_f, valid_f, qf[0]);
      end
    end
  endtask

  task automatic test_sim_boundaries();
    while (qs.size() < 16) step(1, 0, 8'($urandom), 1, 0, 8'($urandom));
    step(1, 1, 8'h77, 1, 1, 8'h77);
    total++;
    if (ovf_s !== 1'b1 || ack_s !== 1'b0 || cnt_s !== 5'd15 || valid_s !== 1'b1 || dout_s !== e_dout_s) begin
      bad++;
      $display("FAIL rw_full_std: got ovf=%b ack=%b cnt=%0d valid=%b dout=%0h expected 1 0 15 1 %0h",
               ovf_s, ack_s, cnt_s, valid_s, dout_s, e_dout_s);
    end
    total++;
    if (ovf_f !== 1'b1 || cnt_f !== 5'd15 || dout_f !== qf[0]) begin
      bad++;
      $display("FAIL rw_full_fw: got ovf=%b cnt=%0d dout=%0h expected 1 15 %0h", ovf_f, cnt_f, dout_f, qf[0]);
    end
    while (qs.size() > 0) step(0, 1, 8'h00, 0, 1, 8'h00);
    step(1, 1, 8'h3C, 1, 1, 8'hC3);
    total++;
    if (unf_s !== 1'b1 || ack_s !== 1'b1 || cnt_s !== 5'd1 || valid_s !== 1'b0) begin
      bad++;
      $display("FAIL rw_empty_std: got unf=%b ack=%b cnt=%0d valid=%b expected 1 1 1 0", unf_s, ack_s, cnt_s, valid_s);
    end
    total++;
    if (unf_f !== 1'b1 || ack_f !== 1'b1 || cnt_f !== 5'd1 || dout_f !== 8'hC3 || valid_f !== 1'b1) begin
      bad++;
      $display("FAIL rw_empty_fw: got unf=%b ack=%b cnt=%0d dout=%0h valid=%b expected 1 1 1 c3 1",
               unf_f, ack_f, cnt_f, dout_f, valid_f);
    end
    step(0, 1, 8'h00, 0, 1, 8'h00);
    total++;
    if (dout_s !== 8'h3C || valid_s !== 1'b1 || empty_s !== 1'b1 || empty_f !== 1'b1) begin
      bad++;
      $display("FAIL rw_empty_readback: got dout=%0h valid=%b empty=%b empty_f=%b expected 3c 1 1 1",
               dout_s, valid_s, empty_s, empty_f);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom),
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 55, 8'($urandom));
      total++;
      if (int'(cnt_s) !== qs.size() || {full_s, empty_s, af_s, ae_s, pf_s, pe_s} !== flags(qs.size()) ||
          {ack_s, ovf_s, unf_s, valid_s} !== {e_ack_s, e_ovf_s, e_unf_s, e_valid_s} || dout_s !== e_dout_s) begin
        bad++;
        $display("FAIL random_std_c%0d: got cnt=%0d flags=%b pulses=%b dout=%0h expected cnt=%0d flags=%b pulses=%b dout=%0h",
                 i, cnt_s, {full_s, empty_s, af_s, ae_s, pf_s, pe_s}, {ack_s, ovf_s, unf_s, valid_s}, dout_s,
                 qs.size(), flags(qs.size()), {e_ack_s, e_ovf_s, e_unf_s, e_valid_s}, e_dout_s);
      end
      total++;
      if (int'(cnt_f) !== qf.size() || {full_f, empty_f, af_f, ae_f, pf_f, pe_f} !== flags(qf.size()) ||
          {ack_f, ovf_f, unf_f, valid_f} !== {e_ack_f, e_ovf_f, e_unf_f, qf.size() > 0} ||
          (qf.size() > 0 && dout_f !== qf[0])) begin
        bad++;
        $display("FAIL random_fw_c%0d: got cnt=%0d flags=%b pulses=%b dout=%0h expected cnt=%0d flags=%b pulses=%b",
                 i, cnt_f, {full_f, empty_f, af_f, ae_f, pf_f, pe_f}, {ack_f, ovf_f, unf_f, valid_f}, dout_f,
                 qf.size(), flags(qf.size()), {e_ack_f, e_ovf_f, e_unf_f, qf.size() > 0});
      end
    end
    while (qs.size() > 0 || qf.size() > 0) step(0, 1, 8'h00, 0, 1, 8'h00);
    step(0, 0, 8'h00, 0, 0, 8'h00);
  endtask

  task automatic test_fwft();
    step(0, 0, 8'h00, 1, 0, 8'hA5);
    total++;
    if (dout_f !== 8'hA5 || valid_f !== 1'b1 || empty_f !== 1'b0) begin
      bad++;
      $display("FAIL fwft_first_word: got dout=%0h valid=%b empty=%b expected a5 1 0", dout_f, valid_f, empty_f);
    end
    step(0, 0, 8'h00, 0, 1, 8'h00);
    total++;
    if (empty_f !== 1'b1 || valid_f !== 1'b0 || cnt_f !== 5'd0) begin
      bad++;
      $display("FAIL fwft_pop: got empty=%b valid=%b cnt=%0d expected 1 0 0", empty_f, valid_f, cnt_f);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom), 1, 0, 8'($urandom));
    step(0, 1, 8'h00, 0, 0, 8'h00);
    wr_s = 0; rd_s = 0; wr_f = 0; rd_f = 0;
    #4;
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (empty_f !== 1'b1 || cnt_f !== 5'd0 || valid_f !== 1'b0 || pe_f !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_fw: got empty=%b cnt=%0d valid=%b pe=%b expected 1 0 0 1", empty_f, cnt_f, valid_f, pe_f);
    end
    total++;
    if (empty_s !== 1'b1 || cnt_s !== 5'd0 || valid_s !== 1'b0 || dout_s !== 8'h00) begin
      bad++;
      $display("FAIL async_reset_std: got empty=%b cnt=%0d valid=%b dout=%0h expected 1 0 0 0",
               empty_s, cnt_s, valid_s, dout_s);
    end
    wr_f = 1; din_f = 8'h99;
    @(posedge clk);
    #1;
    total++;
    if (cnt_f !== 5'd0 || ack_f !== 1'b0) begin
      bad++;
      $display("FAIL write_in_reset: got cnt=%0d ack=%b expected 0 0", cnt_f, ack_f);
    end
    wr_f = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'h5A, 1, 0, 8'h6B);
    total++;
    if (cnt_s !== 5'd1 || cnt_f !== 5'd1 || dout_f !== 8'h6B || ack_s !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_write: got cnt_s=%0d cnt_f=%0d dout_f=%0h ack=%b expected 1 1 6b 1",
               cnt_s, cnt_f, dout_f, ack_s);
    end
    step(0, 1, 8'h00, 0, 1, 8'h00);
    total++;
    if (dout_s !== 8'h5A || valid_s !== 1'b1 || empty_f !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_read: got dout=%0h valid=%b empty_f=%b expected 5a 1 1", dout_s, valid_s, empty_f);
    end
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_sim_boundaries();
    test_random();
    test_fwft();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO that replaces the fixed-configuration FIFO IP used in the FIFO exercise design. It adds configurable width and depth, a first-word-fall-through (FWFT) mode, programmable threshold flags, an occupancy count, and per-cycle handshake and error pulses. It sits between a write-side producer and a read-side consumer in the same clock domain and is driven by the existing 50 MHz fabric clock.

## Interface
Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: address width. DEPTH = 2^ADDR_WIDTH words (16 by default).
- FWFT, 0: read mode. 0 = standard (registered read), 1 = first-word-fall-through.
- PROG_FULL, 12: prog_full asserts when count >= PROG_FULL. Legal range 1..DEPTH.
- PROG_EMPTY, 3: prog_empty asserts when count <= PROG_EMPTY. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- dout  out  DATA_WIDTH  read data.
- valid  out  1  dout holds a valid word (see Operation).
- wr_ack  out  1  one-cycle pulse: the previous-cycle write was accepted.
- overflow  out  1  one-cycle pulse: the previous-cycle write was rejected because the FIFO was full.
- underflow  out  1  one-cycle pulse: the previous-cycle read was rejected because the FIFO was empty.
- full, empty, almost_full, almost_empty  out  1  status flags.
- prog_full, prog_empty  out  1  programmable threshold flags.
- data_count  out  ADDR_WIDTH+1  number of words stored, range 0..DEPTH.

## Operation
- **Storage:** a register array of DEPTH words. Write and read pointers are ADDR_WIDTH bits and wrap modulo DEPTH.
- **Accept rules:**
  - A write is accepted when wr_en=1 and full=0.
  - A read is accepted when rd_en=1 and empty=0.
  - Flags are evaluated from the pre-edge state, so a full FIFO rejects a write even if a read is accepted in the same cycle.
  - An empty FIFO rejects a read even if a write is accepted in the same cycle.
- **Count update:** data_count += accepted_write − accepted_read. A simultaneous accepted read and write leaves the count unchanged and advances both pointers.
- **Flags:** all are decoded from the registered count.
  - full = (count == DEPTH); empty = (count == 0).
  - almost_full = (count >= DEPTH−1); almost_empty = (count <= 1).
  - prog_full and prog_empty use the parameter thresholds.
- **Standard mode (FWFT=0):**
  - On an accepted read, dout is loaded with mem[rd_ptr] at that clock edge, and valid=1 for exactly the following cycle.
  - Otherwise dout holds its last value and valid=0.
- **FWFT mode (FWFT=1):**
  - dout = mem[rd_ptr] combinationally, and valid = ~empty.
  - rd_en acknowledges (pops) the presented word.
  - When empty, dout is don't-care.
- **Reset (async assert):**
  - Pointers and count = 0; dout = 0.
  - valid, wr_ack, overflow, underflow, full, almost_full, prog_full = 0.
  - empty, almost_empty = 1; prog_empty = 1.
  - Reset mid-stream discards all contents; no write or read is accepted while rst=1.
  - Memory contents are not cleared.

## Timing
- Write accepted at edge N: data_count and flags are updated after edge N, and wr_ack=1 during cycle N+1.
- Empty FIFO, write at edge N:
  - empty falls after edge N.
  - FWFT: dout = written word and valid=1 in cycle N+1.
  - Standard: the earliest accepted read is at edge N+1, with data and valid in cycle N+2.
- Standard read latency: 1 cycle from the accepting edge to dout/valid.
- Full FIFO, read at edge N: full falls after edge N, and a write is accepted at edge N+1.
- overflow and underflow are single-cycle pulses following the offending edge; back-to-back rejects give back-to-back pulses.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- **Reset/idle:** assert rst for 5 cycles → empty=1, almost_empty=1, prog_empty=1, data_count=0, every other output 0.
- **Fill to full, standard mode, defaults:** write 0x00..0x0F on consecutive cycles →
  - prog_full rises after the 12th write.
  - almost_full rises after the 15th write.
  - full and data_count=16 after the 16th write.
  - A 17th write gives overflow=1, wr_ack=0, and data_count stays 16.
- **Drain to empty:** 16 reads → dout sequence 0x00..0x0F, each one cycle after its read edge with valid=1. empty is set after the 16th read; a 17th read gives underflow=1 and valid=0.
- **Pointer wrap with simultaneous read/write:** hold 8 words, then do read+write every cycle for 40 cycles → data_count stays 8 and data order is preserved across the wrap.
- **Simultaneous boundary cases:**
  - Read+write while full: read accepted, write rejected (overflow=1), data_count=15.
  - Read+write while empty: write accepted, read rejected (underflow=1), data_count=1.
- **FWFT=1 and mid-operation reset:**
  - Write 0xA5 into an empty FIFO → dout=0xA5 and valid=1 the next cycle. rd_en=1 → empty=1 and valid=0 the next cycle.
  - Write 5 words, then assert rst asynchronously between edges → empty=1 and data_count=0 immediately.
